wb_regfile: RTL and testbench

Write-back stage and architectural register file of the 5-stage pipelined CPU. It consumes the MEM/WB pipeline register outputs and selects the write-back value (ALU result, load data or return address). It commits that value to a 32 x 32-bit register file and serves the two ID-stage read ports with same-cycle write-to-read bypass. It also exports the committed write for the forwarding unit.

---
 rtl/wb_regfile.sv | 107 ++++++++++
 tb/tb_wb_regfile.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back select plus 32x32 architectural register file. Two ID read ports
// and a debug port. The read ports bypass the write committing this cycle.

module wb_rf_rdport (
  input  logic [31:0][31:0] regs_i,
  input  logic [4:0]        addr_i,
  input  logic              byp_en_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_rd_i,
  input  logic [31:0]       wb_data_i,
  output logic [31:0]       data_o
);
  logic hit;

  assign hit = byp_en_i && wb_we_i && (addr_i == wb_rd_i);

  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == 5'd0) data_o = '0;
    else if (hit)       data_o = wb_data_i;
  end
endmodule

module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_07FC,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic [4:0]  MEM2WB_rd_in,
  input  logic [31:0] ALUout_in,
  input  logic [31:0] MEMData_in,
  input  logic [31:0] PCadd4_in,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 32;

  logic [31:0][VEC_W-1:0]          regs_q, regs_d;
  logic [NUM_LANES-1:0][4:0]       rd_addr;
  logic [NUM_LANES-1:0][VEC_W-1:0] rd_data;

  // 2'b11 is reserved and falls back to the ALU result
  always_comb begin
    case (MemtoReg_in)
      2'b01:   wb_data = MEMData_in;
      2'b10:   wb_data = PCadd4_in;
      default: wb_data = ALUout_in;
    endcase
  end

  assign wb_we = RegWrite_in && (MEM2WB_rd_in != 5'd0);
  assign wb_rd = wb_we ? MEM2WB_rd_in : 5'd0;

  always_comb begin
    regs_d = regs_q;
    if (wb_we) regs_d[MEM2WB_rd_in] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q     <= '0;
      regs_q[28] <= GP_INIT;
      regs_q[29] <= SP_INIT;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_addr = {rt_addr, rs_addr};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
    wb_rf_rdport u_port (
      .regs_i    (regs_q),
      .addr_i    (rd_addr[g]),
      .byp_en_i  (1'b1),
      .wb_we_i   (wb_we),
      .wb_rd_i   (wb_rd),
      .wb_data_i (wb_data),
      .data_o    (rd_data[g])
    );
  end

  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];

  // Debug port sees only committed state
  wb_rf_rdport u_dbg (
    .regs_i    (regs_q),
    .addr_i    (dbg_addr),
    .byp_en_i  (1'b0),
    .wb_we_i   (wb_we),
    .wb_rd_i   (wb_rd),
    .wb_data_i (wb_data),
    .data_o    (dbg_data)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus pushes expected outputs, a negedge
// monitor pops and compares them against the live DUT outputs.

module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in;
  logic [1:0]  MemtoReg_in;
  logic [4:0]  MEM2WB_rd_in;
  logic [31:0] ALUout_in, MEMData_in, PCadd4_in;
  logic [4:0]  rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, wb_data, dbg_data;
  logic [4:0]  wb_rd;
  logic        wb_we;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MEM2WB_rd_in(MEM2WB_rd_in),
    .ALUout_in(ALUout_in), .MEMData_in(MEMData_in), .PCadd4_in(PCadd4_in),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t        q[$];
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[29] = 32'h0000_07FC;
    model[28] = 32'h0000_0000;
  endfunction

  function automatic void push(input int sig, input logic [31:0] exp, input string name);
    chk_t c;
    c.sig = sig; c.exp = exp; c.name = name;
    q.push_back(c);
  endfunction

  // Expected read: $0 is zero, bypassing ports see this cycle's write
  function automatic logic [31:0] rexp(input logic [4:0] a, input bit byp,
                                       input logic we, input logic [4:0] rd,
                                       input logic [31:0] w);
    if (a == 5'd0) return 32'h0;
    if (byp && we && a == rd) return w;
    return model[a];
  endfunction

  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    while (q.size() > 0) begin
      c = q.pop_front();
      case (c.sig)
        0:       act = rs_data;
        1:       act = rt_data;
        2:       act = wb_data;
        3:       act = {27'b0, wb_rd};
        4:       act = {31'b0, wb_we};
        default: act = dbg_data;
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, act, c.exp, $time);
      end
    end
  end

  // Called just after a rising edge; returns just after the next one
  task automatic cyc(input logic we, input logic [1:0] sel, input logic [4:0] rd,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                     input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg,
                     input bit rst_mid);
    logic [31:0] w;
    logic        wee;
    RegWrite_in = we; MemtoReg_in = sel; MEM2WB_rd_in = rd;
    ALUout_in = alu; MEMData_in = mem; PCadd4_in = pc;
    rs_addr = rs; rt_addr = rt; dbg_addr = dbg;
    if (rst_mid) begin
      #1 reset = 1'b0;
      model_reset();
    end
    w   = (sel == 2'b01) ? mem : (sel == 2'b10) ? pc : alu;
    wee = we && (rd != 5'd0);
    push(2, w, "wb_data");
    push(4, {31'b0, wee}, "wb_we");
    push(3, wee ? {27'b0, rd} : 32'h0, "wb_rd");
    push(0, rexp(rs, 1'b1, wee, rd, w), "rs_data");
    push(1, rexp(rt, 1'b1, wee, rd, w), "rt_data");
    push(5, rexp(dbg, 1'b0, wee, rd, w), "dbg_data");
    @(posedge clk);
    if (reset && wee) model[rd] = w;
    #1;
  endtask

  function automatic logic [4:0] ra();
    return ($urandom % 3 == 0) ? 5'($urandom % 32) : 5'($urandom % 8);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    RegWrite_in = 0; MemtoReg_in = 0; MEM2WB_rd_in = 0;
    ALUout_in = 0; MEMData_in = 0; PCadd4_in = 0;
    rs_addr = 0; rt_addr = 0; dbg_addr = 0;
    model_reset();
    @(posedge clk); #1;
    // reset state, all inputs zero, then reset values of $29/$28
    cyc(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd29, 5'd29, 5'd28, 0);
    reset = 1'b1;

    // source select on $8, dbg confirms each commit on the following cycle
    for (int s = 0; s < 4; s++)
      cyc(1, 2'(s), 5'd8, 32'hA, 32'hB, 32'hC, 5'd8, 5'd1, 5'd8, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 0);

    // bypass on both ports; dbg still old until the edge
    cyc(1, 2'b00, 5'd3, 32'hDEAD_BEEF, 0, 0, 5'd3, 5'd3, 5'd3, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd3, 5'd0, 5'd3, 0);

    // $0 protection
    cyc(1, 2'b00, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);

    // disabled write
    cyc(0, 2'b00, 5'd4, 32'h55, 0, 0, 5'd4, 5'd4, 5'd4, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd4, 5'd4, 5'd4, 0);

    // link write then back-to-back overwrite of $31
    cyc(1, 2'b10, 5'd31, 32'h1, 32'h2, 32'h40, 5'd31, 5'd30, 5'd31, 0);
    cyc(1, 2'b00, 5'd31, 32'h44, 32'h2, 32'h48, 5'd31, 5'd31, 5'd31, 0);
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd31, 5'd31, 5'd31, 0);

    // mid-cycle async reset after writing $5; a write during reset is lost
    cyc(1, 2'b00, 5'd5, 32'h1234, 0, 0, 5'd5, 5'd5, 5'd5, 0);
    cyc(1, 2'b00, 5'd6, 32'h99, 0, 0, 5'd5, 5'd29, 5'd28, 1);
    reset = 1'b1;
    cyc(0, 2'b00, 0, 0, 0, 0, 5'd5, 5'd6, 5'd6, 0);

    // randomized traffic with occasional mid-cycle resets
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom % 4) != 0, 2'($urandom), ra(), $urandom, $urandom, $urandom,
          ra(), ra(), ra(), ($urandom % 60) == 0);
      reset = 1'b1;
    end

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
